adder_sweep_sequencer: RTL and testbench

- Automatic measurement sequencer that sits directly upstream of instrumented_adder_sklansky and drives its control inputs in place of hand-toggled logic-analyzer bits.
- It walks a mask of adder bit positions. For each selected bit it resets the adder, selects that bit's ring path, loads and runs the integration counter, then captures ring_osc_counter_out when done rises.
- Results are held in a per-bit register file that the CPU reads back over the logic analyzer.

---
 rtl/adder_sweep_sequencer_if.sv | 28 ++
 rtl/adder_sweep_sequencer.sv | 156 +++++++++++++++
 tb/tb_adder_sweep_sequencer.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_sweep_sequencer_if.sv
// Control/observe bundle between the sweep sequencer and the instrumented adder.
// The sequencer is the master and drives the adder's measurement controls.
interface adder_sweep_sequencer_if #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 32
);
  logic               adder_reset;
  logic               adder_stop_b;
  logic               adder_counter_load;
  logic               adder_counter_enable;
  logic [COUNT_W-1:0] adder_integration_time;
  logic [WIDTH-1:0]   adder_ring_bit_b;
  logic [WIDTH-1:0]   adder_sum_bit_b;
  logic               adder_done;
  logic [COUNT_W-1:0] adder_count;

  modport master (
    output adder_reset, adder_stop_b, adder_counter_load, adder_counter_enable,
           adder_integration_time, adder_ring_bit_b, adder_sum_bit_b,
    input  adder_done, adder_count
  );

  modport slave (
    input  adder_reset, adder_stop_b, adder_counter_load, adder_counter_enable,
           adder_integration_time, adder_ring_bit_b, adder_sum_bit_b,
    output adder_done, adder_count
  );
endinterface

// File: rtl/adder_sweep_sequencer.sv
// Walks a mask of adder bits, runs one ring-oscillator integration per selected bit
// and stores the captured counts in a per-bit result file readable over rd_index.
module adder_sweep_sequencer #(
  parameter int WIDTH       = 8,
  parameter int COUNT_W     = 32,
  parameter int SETTLE      = 4,
  parameter int GUARD       = 2,
  parameter int WDOG_MARGIN = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [WIDTH-1:0]         bit_mask,
  input  logic [COUNT_W-1:0]       integration_time,
  output logic                     busy,
  output logic                     sweep_done,
  output logic                     timeout_err,
  input  logic [$clog2(WIDTH)-1:0] rd_index,
  output logic [COUNT_W-1:0]       rd_data,
  output logic                     rd_valid,
  adder_sweep_sequencer_if.master  ad
);
  localparam int IW = $clog2(WIDTH);
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {IDLE, SELECT, RST, LOAD, RUN, CAPT, STOP, FIN} state_t;

  state_t             state;
  logic [IW-1:0]      idx;
  logic [WIDTH-1:0]   mask;
  logic [SW-1:0]      settle_cnt;
  logic [COUNT_W:0]   wdog, wdog_lim;
  logic [COUNT_W-1:0] res [WIDTH];
  logic [WIDTH-1:0]   valid;
  logic               last;
  logic [WIDTH-1:0]   sel_b;

  assign last  = (idx == IW'(WIDTH-1));
  assign sel_b = ~(WIDTH'(1) << idx);

  always_ff @(posedge clk) begin
    if (reset) begin
      state                     <= IDLE;
      idx                       <= '0;
      mask                      <= '0;
      settle_cnt                <= '0;
      wdog                      <= '0;
      wdog_lim                  <= '0;
      busy                      <= 1'b0;
      sweep_done                <= 1'b0;
      timeout_err               <= 1'b0;
      valid                     <= '0;
      ad.adder_reset            <= 1'b0;
      ad.adder_stop_b           <= 1'b0;
      ad.adder_counter_load     <= 1'b0;
      ad.adder_counter_enable   <= 1'b0;
      ad.adder_integration_time <= '0;
      ad.adder_ring_bit_b       <= '1;
      ad.adder_sum_bit_b        <= '1;
      for (int i = 0; i < WIDTH; i++) res[i] <= '0;
    end else begin
      sweep_done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          mask                      <= bit_mask;
          ad.adder_integration_time <= integration_time;
          // one extra bit so time + margin can never wrap
          wdog_lim    <= {1'b0, integration_time} + (COUNT_W+1)'(WDOG_MARGIN);
          valid       <= '0;
          timeout_err <= 1'b0;
          idx         <= '0;
          busy        <= 1'b1;
          state       <= SELECT;
        end
        SELECT: begin
          if (mask[idx]) begin
            state               <= RST;
            settle_cnt          <= '0;
            ad.adder_reset      <= 1'b1;
            ad.adder_stop_b     <= 1'b0;
            ad.adder_ring_bit_b <= sel_b;
            ad.adder_sum_bit_b  <= sel_b;
          end else if (last) begin
            state      <= FIN;
            sweep_done <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        RST: begin
          if (settle_cnt == SW'(SETTLE-1)) begin
            state                 <= LOAD;
            ad.adder_reset        <= 1'b0;
            ad.adder_counter_load <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        LOAD: begin
          state                   <= RUN;
          ad.adder_counter_load   <= 1'b0;
          ad.adder_stop_b         <= 1'b1;
          ad.adder_counter_enable <= 1'b1;
          wdog                    <= (COUNT_W+1)'(1);
        end
        RUN: begin
          // wdog holds the 1-based RUN cycle number; done beats the watchdog on a tie
          if (wdog > (COUNT_W+1)'(GUARD) && ad.adder_done) begin
            state <= CAPT;
          end else if (wdog >= wdog_lim) begin
            state                   <= STOP;
            timeout_err             <= 1'b1;
            ad.adder_stop_b         <= 1'b0;
            ad.adder_counter_enable <= 1'b0;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        CAPT: begin
          res[idx]                <= ad.adder_count;
          valid[idx]              <= 1'b1;
          state                   <= STOP;
          ad.adder_stop_b         <= 1'b0;
          ad.adder_counter_enable <= 1'b0;
        end
        STOP: begin
          ad.adder_ring_bit_b <= '1;
          ad.adder_sum_bit_b  <= '1;
          if (last) begin
            state      <= FIN;
            sweep_done <= 1'b1;
          end else begin
            idx   <= idx + 1'b1;
            state <= SELECT;
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Registered read: a same-cycle capture is seen one cycle later
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_data  <= res[rd_index];
      rd_valid <= valid[rd_index];
    end
  end
endmodule

// File: tb/tb_adder_sweep_sequencer.sv
// Bench for adder_sweep_sequencer: behavioural adder model, activity monitor and a
// cycle-cost reference computed per bit from the sweep rules.
module tb_adder_sweep_sequencer;
  localparam int W = 8, CW = 32, SETTLE = 4, GUARD = 2, MARGIN = 64;
  localparam int BUDGET = 20000;

  logic          clk = 1'b0;
  logic          reset = 1'b1, start = 1'b0;
  logic [W-1:0]  bit_mask = '0;
  logic [CW-1:0] integration_time = '0;
  logic          busy, sweep_done, timeout_err;
  logic [2:0]    rd_index = '0;
  logic [CW-1:0] rd_data;
  logic          rd_valid;

  adder_sweep_sequencer_if #(.WIDTH(W), .COUNT_W(CW)) ad ();

  adder_sweep_sequencer #(.WIDTH(W), .COUNT_W(CW), .SETTLE(SETTLE), .GUARD(GUARD),
                          .WDOG_MARGIN(MARGIN)) dut (
    .clk(clk), .reset(reset), .start(start), .bit_mask(bit_mask),
    .integration_time(integration_time), .busy(busy), .sweep_done(sweep_done),
    .timeout_err(timeout_err), .rd_index(rd_index), .rd_data(rd_data),
    .rd_valid(rd_valid), .ad(ad)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Adder model: done after m_delay enabled cycles since load; count = base + ring bit
  int            m_delay = 10;
  bit            m_never = 1'b0, m_hold = 1'b0;
  logic [CW-1:0] m_base = '0;
  int            m_run = 0;

  function automatic int ring_idx(input logic [W-1:0] rb);
    for (int i = 0; i < W; i++) if (!rb[i]) return i;
    return 0;
  endfunction

  always @(negedge clk) begin
    if (ad.adder_counter_load) m_run = 0;
    else if (ad.adder_counter_enable) m_run++;
    ad.adder_done  = m_hold || (!m_never && ad.adder_counter_enable && m_run >= m_delay);
    ad.adder_count = m_base + CW'(ring_idx(ad.adder_ring_bit_b));
  end

  // Monitor: run lengths of adder_reset / counter_enable, ring select at each load
  int           rst_run = 0, en_run = 0, n_done = 0, n_bad = 0, n_act = 0;
  int           rst_q[$], en_q[$];
  logic [W-1:0] ring_q[$];

  always @(negedge clk) begin
    if (ad.adder_reset) rst_run++;
    else if (rst_run > 0) begin rst_q.push_back(rst_run); rst_run = 0; end
    if (ad.adder_counter_enable) en_run++;
    else if (en_run > 0) begin en_q.push_back(en_run); en_run = 0; end
    if (ad.adder_counter_load) ring_q.push_back(ad.adder_ring_bit_b);
    if (sweep_done) n_done++;
    if (ad.adder_sum_bit_b !== ad.adder_ring_bit_b) n_bad++;
    if (ad.adder_reset || ad.adder_counter_load || ad.adder_counter_enable || ad.adder_stop_b)
      n_act++;
  end

  int s_rst, s_en, s_ring, s_done, s_bad, s_act;

  // Per selected bit: enabled-cycle length and whether it gets captured
  function automatic void bit_plan(input int it, output int en_len, output bit cap);
    int r, lim;
    lim = it + MARGIN;
    r   = m_hold ? GUARD + 1 : (m_delay > GUARD ? m_delay : GUARD + 1);
    if ((m_never && !m_hold) || r > lim) begin cap = 1'b0; en_len = lim; end
    else begin cap = 1'b1; en_len = r + 1; end
  endfunction

  // SELECT 1 + RST + LOAD 1 + enabled cycles + STOP 1 per measured bit, 1 per skipped bit
  function automatic int exp_latency(input logic [W-1:0] mask, input int it);
    int lat, en_len;
    bit cap;
    lat = 1;
    for (int i = 0; i < W; i++) begin
      if (!mask[i]) lat += 1;
      else begin bit_plan(it, en_len, cap); lat += SETTLE + 3 + en_len; end
    end
    return lat;
  endfunction

  task automatic snapshot();
    s_rst = rst_q.size(); s_en = en_q.size(); s_ring = ring_q.size();
    s_done = n_done; s_bad = n_bad; s_act = n_act;
  endtask

  task automatic run_sweep(input logic [W-1:0] mask, input int it, input bit poke,
                           output int lat);
    int n;
    snapshot();
    @(negedge clk); bit_mask = mask; integration_time = CW'(it); start = 1'b1;
    @(negedge clk); start = 1'b0; n = 1;
    check("busy_after_start", busy, 1'b1);
    while (!sweep_done && n < BUDGET) begin
      @(negedge clk); n++;
      start = poke && (n == 5);
    end
    lat = n;
    check("sweep_done_seen", sweep_done, 1'b1);
    if (poke) start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("busy_drop", busy, 1'b0);
    check("sweep_done_one_cycle", sweep_done, 1'b0);
    @(negedge clk);
    check("no_restart", busy, 1'b0);
  endtask

  task automatic readback(input logic [W-1:0] expv, input logic [CW-1:0] base);
    for (int i = 0; i < W; i++) begin
      @(negedge clk); rd_index = 3'(i);
      @(negedge clk);
      check($sformatf("rd_valid[%0d]", i), rd_valid, expv[i]);
      if (expv[i]) check($sformatf("rd_data[%0d]", i), rd_data, base + CW'(i));
    end
  endtask

  task automatic verify(input logic [W-1:0] mask, input int it, input int lat);
    int           en_len, k, nsel;
    bit           cap, exp_to;
    logic [W-1:0] expv, ring_exp;
    expv = '0; exp_to = 1'b0; k = 0; nsel = $countones(mask);
    check("latency", lat, exp_latency(mask, it));
    check("done_pulses", n_done - s_done, 1);
    check("load_pulses", ring_q.size() - s_ring, nsel);
    check("rst_runs", rst_q.size() - s_rst, nsel);
    check("en_runs", en_q.size() - s_en, nsel);
    check("sum_eq_ring", n_bad - s_bad, 0);
    for (int i = 0; i < W; i++) begin
      if (mask[i]) begin
        bit_plan(it, en_len, cap);
        if (cap) expv[i] = 1'b1; else exp_to = 1'b1;
        ring_exp = ~(W'(1) << i);
        if (ring_q.size() > s_ring + k)
          check($sformatf("ring_b_bit%0d", i), ring_q[s_ring + k], ring_exp);
        if (rst_q.size() > s_rst + k)
          check($sformatf("rst_len_bit%0d", i), rst_q[s_rst + k], SETTLE);
        if (en_q.size() > s_en + k)
          check($sformatf("en_len_bit%0d", i), en_q[s_en + k], en_len);
        k++;
      end
    end
    check("timeout_err", timeout_err, exp_to);
    check("int_time_latched", ad.adder_integration_time, CW'(it));
    readback(expv, m_base);
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, n, it;
    logic [W-1:0] mask;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_sweep_done", sweep_done, 1'b0);
    check("rst_timeout_err", timeout_err, 1'b0);
    check("rst_adder_reset", ad.adder_reset, 1'b0);
    check("rst_stop_b", ad.adder_stop_b, 1'b0);
    check("rst_load", ad.adder_counter_load, 1'b0);
    check("rst_enable", ad.adder_counter_enable, 1'b0);
    check("rst_ring_b", ad.adder_ring_bit_b, 8'hFF);
    check("rst_sum_b", ad.adder_sum_bit_b, 8'hFF);
    check("rst_rd_valid", rd_valid, 1'b0);
    reset = 1'b0;

    // Single bit, done 100 cycles into RUN
    m_delay = 100; m_base = 32'h1234;
    run_sweep(8'h01, 100, 1'b0, lat);
    verify(8'h01, 100, lat);

    // Sparse mask, ascending order
    m_delay = 15; m_base = 32'd1000;
    run_sweep(8'hA5, 100, 1'b0, lat);
    verify(8'hA5, 100, lat);

    // Done never comes: 10 + 64 RUN cycles then timeout
    m_never = 1'b1;
    run_sweep(8'h04, 10, 1'b0, lat);
    verify(8'h04, 10, lat);
    check("timeout_run_len", (en_q.size() > s_en) ? en_q[s_en] : 0, 74);
    m_never = 1'b0;

    // Done lands exactly on the watchdog limit: captured, no timeout
    m_delay = 74; m_base = 32'hCAFE0000;
    run_sweep(8'h02, 10, 1'b0, lat);
    verify(8'h02, 10, lat);

    // Done held high: guard window, plus start pokes while busy and in FIN
    m_hold = 1'b1; m_base = 32'h00ABCD00;
    run_sweep(8'h12, 50, 1'b1, lat);
    verify(8'h12, 50, lat);
    m_hold = 1'b0;

    // Empty mask
    run_sweep(8'h00, 20, 1'b0, lat);
    verify(8'h00, 20, lat);
    check("zero_mask_latency", lat, 9);
    check("zero_mask_no_activity", n_act - s_act, 0);

    // Reset in the middle of bit 3's RUN
    m_delay = 20; m_base = 32'h5000;
    snapshot();
    @(negedge clk); bit_mask = 8'hFF; integration_time = 32'd100; start = 1'b1;
    @(negedge clk); start = 1'b0; n = 0;
    while (!(ad.adder_ring_bit_b == 8'hF7 && ad.adder_counter_enable) && n < BUDGET) begin
      @(negedge clk); n++;
    end
    check("reached_bit3_run", n < BUDGET, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", sweep_done, 1'b0);
    check("mid_rst_enable", ad.adder_counter_enable, 1'b0);
    check("mid_rst_stop_b", ad.adder_stop_b, 1'b0);
    check("mid_rst_ring_b", ad.adder_ring_bit_b, 8'hFF);
    check("mid_rst_int_time", ad.adder_integration_time, 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_rst_no_sweep_done", n_done - s_done, 0);
    readback(8'h00, 32'h0);
    run_sweep(8'hFF, 100, 1'b0, lat);
    verify(8'hFF, 100, lat);

    // Randomized sweeps
    for (int t = 0; t < 5; t++) begin
      mask    = W'($urandom);
      it      = $urandom_range(0, 60);
      m_delay = $urandom_range(1, 130);
      m_never = ($urandom_range(0, 3) == 0);
      m_base  = $urandom;
      run_sweep(mask, it, 1'b0, lat);
      verify(mask, it, lat);
    end
    m_never = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
